itch_decode_arbiter: RTL and testbench

Collects completion pulses from the parallel speculative ITCH decoders (add, cancel, delete, replace, ...) and serialises them into one message stream with a valid/ready handshake. It resolves simultaneous completions by fixed priority and buffers results in a small FIFO, so a stalled consumer never blocks the byte-rate decoders. It also keeps saturating statistics for messages, conflicts, invalid packets and drops. It sits between the decoder bank and the order-book/output stage.

---
 rtl/itch_arb_pkg.sv | 35 +++
 rtl/itch_msg_fifo.sv | 86 ++++++++
 rtl/itch_decode_arbiter.sv | 137 +++++++++++++
 tb/tb_itch_decode_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/itch_arb_pkg.sv
// ----------------------------------------------------------------------------
// itch_arb_pkg
// Shared definitions for the ITCH decoder arbiter.
//   TYPE_W         width of the ITCH parsed-type code
//   PAYLOAD_W_DEF  default packed payload width per decoder
//   SRC_W_DEF      default source-index width (4 decoders)
//   T_*            parsed-type codes emitted by the decoders
//   entry_t        default FIFO entry {msg_type, src, payload}
//   is_multi_hot   true when more than one bit of an 8-bit vector is set
// ----------------------------------------------------------------------------
package itch_arb_pkg;

    localparam int TYPE_W        = 4;
    localparam int PAYLOAD_W_DEF = 192;
    localparam int SRC_W_DEF     = 2;

    localparam logic [TYPE_W-1:0] T_NONE    = 4'd0;
    localparam logic [TYPE_W-1:0] T_ADD     = 4'd1;
    localparam logic [TYPE_W-1:0] T_CANCEL  = 4'd2;
    localparam logic [TYPE_W-1:0] T_DELETE  = 4'd3;
    localparam logic [TYPE_W-1:0] T_REPLACE = 4'd4;
    localparam logic [TYPE_W-1:0] T_EXECUTE = 4'd5;

    typedef struct packed {
        logic [TYPE_W-1:0]        msg_type;
        logic [SRC_W_DEF-1:0]     src;
        logic [PAYLOAD_W_DEF-1:0] payload;
    } entry_t;

    // Clearing the lowest set bit leaves something only if two or more were set.
    function automatic logic is_multi_hot(input logic [7:0] v);
        return (v & (v - 8'd1)) != 8'd0;
    endfunction

endpackage

// File: rtl/itch_msg_fifo.sv
// ----------------------------------------------------------------------------
// itch_msg_fifo
// Synchronous FIFO with first-word-fall-through head, occupancy and flush.
//   clk, rst_n   clock, async active-low reset
//   flush        empties the FIFO next cycle; a same-cycle push is discarded
//   push/wr_data write request and entry; ignored when full unless popping
//   pop          consume head (ignored when empty)
//   rd_data      head entry; holds the last presented head while empty
//   full, empty  status
//   level        true occupancy 0..DEPTH
// ----------------------------------------------------------------------------
module itch_msg_fifo
    import itch_arb_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = entry_t
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  T                         wr_data,
    input  logic                     pop,
    output T                         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    T               mem [DEPTH];
    T               hold_q;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           wr_en;
    logic           rd_en;

    assign empty = (level == '0);
    assign full  = (level == LW'(DEPTH));

    assign rd_en = pop & ~empty & ~flush;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign wr_en = push & ~flush & (~full | rd_en);

    // Show the head directly; when empty, keep showing what was last presented.
    assign rd_data = empty ? hold_q : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            hold_q <= '0;
        end else begin
            if (!empty) begin
                hold_q <= mem[rd_ptr];
            end
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                if (wr_en) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (rd_en) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                case ({wr_en, rd_en})
                    2'b10:   level <= level + LW'(1);
                    2'b01:   level <= level - LW'(1);
                    default: level <= level;
                endcase
            end
        end
    end

endmodule

// File: rtl/itch_decode_arbiter.sv
// ----------------------------------------------------------------------------
// itch_decode_arbiter
// Serialises completion pulses from parallel ITCH decoders into one
// valid/ready stream, lowest decoder index wins, with saturating statistics.
//   clk, rst_n                        clock, async active-low reset
//   dec_valid/dec_invalid [NUM_DEC]   per-decoder completion / invalid pulses
//   dec_type    [4*NUM_DEC]           parsed type, slice i = [4i+3:4i]
//   dec_payload [PAYLOAD_W*NUM_DEC]   packed fields, slice i at [PAYLOAD_W*i +: PAYLOAD_W]
//   out_valid/out_ready               head handshake
//   out_type, out_src, out_payload    head entry (registered, FWFT)
//   flush, clr_stats                  synchronous FIFO clear / statistics clear
//   msg_count, conflict_count,
//   invalid_count, drop_count         saturating statistics
//   overflow                          sticky drop flag
//   fifo_level                        FIFO occupancy
// ----------------------------------------------------------------------------
module itch_decode_arbiter
    import itch_arb_pkg::*;
#(
    parameter int NUM_DEC    = 4,
    parameter int PAYLOAD_W  = PAYLOAD_W_DEF,
    parameter int FIFO_DEPTH = 4,
    parameter int SRC_W      = $clog2(NUM_DEC)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_DEC-1:0]              dec_valid,
    input  logic [NUM_DEC-1:0]              dec_invalid,
    input  logic [TYPE_W*NUM_DEC-1:0]       dec_type,
    input  logic [PAYLOAD_W*NUM_DEC-1:0]    dec_payload,
    input  logic                            out_ready,
    output logic                            out_valid,
    output logic [TYPE_W-1:0]               out_type,
    output logic [SRC_W-1:0]                out_src,
    output logic [PAYLOAD_W-1:0]            out_payload,
    input  logic                            flush,
    input  logic                            clr_stats,
    output logic [31:0]                     msg_count,
    output logic [15:0]                     conflict_count,
    output logic [15:0]                     invalid_count,
    output logic [15:0]                     drop_count,
    output logic                            overflow,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

    typedef struct packed {
        logic [TYPE_W-1:0]    msg_type;
        logic [SRC_W-1:0]     src;
        logic [PAYLOAD_W-1:0] payload;
    } arb_entry_t;

    arb_entry_t           win_entry;
    arb_entry_t           head_entry;
    logic                 push;
    logic                 pop;
    logic                 multi;
    logic                 any_invalid;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 accepted;
    logic                 dropped;

    // Walk from the top down so the lowest set index is the final assignment.
    always_comb begin
        win_entry = '0;
        for (int i = NUM_DEC - 1; i >= 0; i--) begin
            if (dec_valid[i]) begin
                win_entry.msg_type = dec_type[TYPE_W*i +: TYPE_W];
                win_entry.src      = SRC_W'(i);
                win_entry.payload  = dec_payload[PAYLOAD_W*i +: PAYLOAD_W];
            end
        end
    end

    assign push        = |dec_valid;
    assign multi       = is_multi_hot(8'(dec_valid));
    assign any_invalid = |dec_invalid;
    assign pop         = out_valid & out_ready;

    // Same acceptance rule the FIFO applies internally; used only for stats.
    assign accepted = push & ~flush & (~fifo_full | pop);
    assign dropped  = push & ~flush & fifo_full & ~pop;

    itch_msg_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (arb_entry_t)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .push    (push),
        .wr_data (win_entry),
        .pop     (pop),
        .rd_data (head_entry),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign out_valid   = ~fifo_empty;
    assign out_type    = head_entry.msg_type;
    assign out_src     = head_entry.src;
    assign out_payload = head_entry.payload;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msg_count      <= '0;
            conflict_count <= '0;
            invalid_count  <= '0;
            drop_count     <= '0;
            overflow       <= 1'b0;
        end else if (clr_stats) begin
            msg_count      <= '0;
            conflict_count <= '0;
            invalid_count  <= '0;
            drop_count     <= '0;
            overflow       <= 1'b0;
        end else begin
            if (accepted && (msg_count != '1)) begin
                msg_count <= msg_count + 32'd1;
            end
            if (multi && (conflict_count != '1)) begin
                conflict_count <= conflict_count + 16'd1;
            end
            if (any_invalid && (invalid_count != '1)) begin
                invalid_count <= invalid_count + 16'd1;
            end
            if (dropped) begin
                overflow <= 1'b1;
                if (drop_count != '1) begin
                    drop_count <= drop_count + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_itch_decode_arbiter.sv
module tb_itch_decode_arbiter;
    import itch_arb_pkg::*;

    localparam int N  = 4;
    localparam int PW = 192;
    localparam int D  = 4;
    localparam int SW = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      dec_valid = '0;
    logic [N-1:0]      dec_invalid = '0;
    logic [4*N-1:0]    dec_type = '0;
    logic [PW*N-1:0]   dec_payload = '0;
    logic              out_ready = 1'b0;
    logic              out_valid;
    logic [3:0]        out_type;
    logic [SW-1:0]     out_src;
    logic [PW-1:0]     out_payload;
    logic              flush = 1'b0;
    logic              clr_stats = 1'b0;
    logic [31:0]       msg_count;
    logic [15:0]       conflict_count;
    logic [15:0]       invalid_count;
    logic [15:0]       drop_count;
    logic              overflow;
    logic [2:0]        fifo_level;

    itch_decode_arbiter #(
        .NUM_DEC(N), .PAYLOAD_W(PW), .FIFO_DEPTH(D)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .dec_valid(dec_valid), .dec_invalid(dec_invalid),
        .dec_type(dec_type), .dec_payload(dec_payload),
        .out_ready(out_ready), .out_valid(out_valid),
        .out_type(out_type), .out_src(out_src), .out_payload(out_payload),
        .flush(flush), .clr_stats(clr_stats),
        .msg_count(msg_count), .conflict_count(conflict_count),
        .invalid_count(invalid_count), .drop_count(drop_count),
        .overflow(overflow), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]    t;
        logic [SW-1:0] s;
        logic [PW-1:0] p;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    int unsigned e_msg = 0;
    int unsigned e_conf = 0;
    int unsigned e_inv = 0;
    int unsigned e_drop = 0;
    logic        e_ovf = 1'b0;

    task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] rand_payload();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check_all();
        chk("out_valid",      PW'(out_valid),      PW'(sb.size() != 0));
        chk("fifo_level",     PW'(fifo_level),     PW'(sb.size()));
        chk("msg_count",      PW'(msg_count),      PW'(e_msg));
        chk("conflict_count", PW'(conflict_count), PW'(e_conf));
        chk("invalid_count",  PW'(invalid_count),  PW'(e_inv));
        chk("drop_count",     PW'(drop_count),     PW'(e_drop));
        chk("overflow",       PW'(overflow),       PW'(e_ovf));
    endtask

    task automatic drive(input int i, input logic [3:0] t, input logic [PW-1:0] p);
        dec_valid[i]            = 1'b1;
        dec_type[4*i +: 4]      = t;
        dec_payload[PW*i +: PW] = p;
    endtask

    // One clock: compare any head being consumed, update the model from the
    // inputs currently driven, clock, clear pulses, then check state.
    task automatic cycle();
        logic popping;
        logic acc;
        logic drp;
        int   w;
        exp_t e;
        popping = out_ready && (sb.size() != 0);
        if (popping) begin
            chk("head_type",    PW'(out_type), PW'(sb[0].t));
            chk("head_src",     PW'(out_src),  PW'(sb[0].s));
            chk("head_payload", out_payload,   sb[0].p);
        end
        w = -1;
        for (int i = N - 1; i >= 0; i--) if (dec_valid[i]) w = i;
        acc = 1'b0;
        drp = 1'b0;
        if (flush) begin
            sb.delete();
        end else begin
            if (popping) void'(sb.pop_front());
            if (w >= 0) begin
                if (sb.size() < D) begin
                    e.t = dec_type[4*w +: 4];
                    e.s = SW'(w);
                    e.p = dec_payload[PW*w +: PW];
                    sb.push_back(e);
                    acc = 1'b1;
                end else begin
                    drp = 1'b1;
                end
            end
        end
        if (clr_stats) begin
            e_msg = 0; e_conf = 0; e_inv = 0; e_drop = 0; e_ovf = 1'b0;
        end else begin
            if (acc && e_msg != 32'hFFFF_FFFF) e_msg++;
            if ($countones(dec_valid) > 1 && e_conf != 16'hFFFF) e_conf++;
            if ((|dec_invalid) && e_inv != 16'hFFFF) e_inv++;
            if (drp) begin
                e_ovf = 1'b1;
                if (e_drop != 16'hFFFF) e_drop++;
            end
        end
        @(posedge clk);
        #1;
        dec_valid   = '0;
        dec_invalid = '0;
        flush       = 1'b0;
        clr_stats   = 1'b0;
        check_all();
    endtask

    task automatic drain();
        int guard;
        out_ready = 1'b1;
        guard = 0;
        while (sb.size() != 0 && guard < 20) begin
            cycle();
            guard++;
        end
        chk("drain_done", PW'(sb.size()), PW'(0));
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_out_valid",   PW'(out_valid),   PW'(0));
        chk("rst_out_type",    PW'(out_type),    PW'(0));
        chk("rst_out_src",     PW'(out_src),     PW'(0));
        chk("rst_out_payload", out_payload,      PW'(0));
        chk("rst_fifo_level",  PW'(fifo_level),  PW'(0));
        chk("rst_msg_count",   PW'(msg_count),   PW'(0));
        chk("rst_overflow",    PW'(overflow),    PW'(0));
        #10;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single completion from decoder 3
        out_ready = 1'b1;
        drive(3, T_REPLACE, rand_payload());
        cycle();
        chk("single_valid", PW'(out_valid), PW'(1));
        chk("single_src",   PW'(out_src),   PW'(3));
        cycle();

        // Conflict between decoders 1 and 2: only decoder 1 is kept
        drive(1, T_CANCEL, rand_payload());
        drive(2, T_DELETE, rand_payload());
        cycle();
        chk("conflict_src", PW'(out_src), PW'(1));
        cycle();

        // Backpressure: five pushes into four entries
        out_ready = 1'b0;
        drive(0, T_ADD,     rand_payload()); cycle();
        drive(1, T_CANCEL,  rand_payload()); cycle();
        drive(2, T_DELETE,  rand_payload()); cycle();
        drive(3, T_REPLACE, rand_payload()); cycle();
        drive(0, T_EXECUTE, rand_payload()); cycle();
        chk("full_level", PW'(fifo_level), PW'(4));
        chk("full_drop",  PW'(drop_count), PW'(1));
        chk("full_ovf",   PW'(overflow),   PW'(1));

        // Full with simultaneous push and pop
        out_ready = 1'b1;
        drive(2, T_ADD, rand_payload());
        cycle();
        chk("fullpp_level", PW'(fifo_level), PW'(4));
        chk("fullpp_drop",  PW'(drop_count), PW'(1));
        drain();

        // Flush discards queued entries and a same-cycle push
        out_ready = 1'b0;
        drive(1, T_ADD, rand_payload()); cycle();
        drive(2, T_ADD, rand_payload()); cycle();
        flush = 1'b1;
        drive(0, T_DELETE, rand_payload());
        cycle();
        chk("flush_level", PW'(fifo_level), PW'(0));
        out_ready = 1'b1;
        drive(0, T_CANCEL, rand_payload()); cycle();
        cycle();

        // Invalid pulses count once per cycle; saturation
        dec_invalid = 4'b0011;
        cycle();
        for (int k = 0; k < 65537; k++) begin
            dec_invalid = 4'b0001;
            cycle();
        end
        chk("inv_saturated", PW'(invalid_count), PW'(16'hFFFF));

        // Clear has priority over a same-cycle event
        clr_stats   = 1'b1;
        dec_invalid = 4'b1000;
        drive(1, T_ADD, rand_payload());
        drive(3, T_ADD, rand_payload());
        cycle();
        chk("clr_inv", PW'(invalid_count), PW'(0));
        chk("clr_ovf", PW'(overflow),      PW'(0));
        drain();

        // Asynchronous reset mid-stream with three entries queued
        out_ready = 1'b0;
        drive(0, T_ADD, rand_payload()); cycle();
        drive(1, T_ADD, rand_payload()); cycle();
        drive(2, T_ADD, rand_payload()); cycle();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", PW'(out_valid),  PW'(0));
        chk("arst_level",     PW'(fifo_level), PW'(0));
        chk("arst_type",      PW'(out_type),   PW'(0));
        chk("arst_payload",   out_payload,     PW'(0));
        chk("arst_msg",       PW'(msg_count),  PW'(0));
        sb.delete();
        e_msg = 0; e_conf = 0; e_inv = 0; e_drop = 0; e_ovf = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drive(2, T_REPLACE, rand_payload());
        cycle();
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
